// File: rtl/multicycle_data_path.sv
// Multi-cycle RV32 datapath: PC, IR, register file, immediate generator, ALU and
// inter-step registers, sequenced by an FSM with req/ready memory handshakes.
module multicycle_data_path #(
  parameter int PC_W       = 8,
  parameter int DATA_W     = 32,
  parameter int RF_ADDRESS = 5,
  parameter int DM_ADDRESS = 9,
  parameter int ALU_CC_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic                  mem2reg,
  input  logic                  alu_src,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic                  branch,
  input  logic [ALU_CC_W-1:0]   alu_cc,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  imem_ready,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DM_ADDRESS-1:0] dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ready,
  output logic [6:0]            opcode,
  output logic [6:0]            funct7,
  output logic [2:0]            funct3,
  output logic [DATA_W-1:0]     alu_result,
  output logic                  instr_done,
  input  logic [RF_ADDRESS-1:0] dbg_rf_addr,
  output logic [DATA_W-1:0]     dbg_rf_data
);

  localparam int RF_DEPTH = 1 << RF_ADDRESS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t state, state_next;
  logic   done_next;

  logic [PC_W-1:0]       pc, old_pc;
  logic [31:0]           ir;
  logic [DATA_W-1:0]     a_reg, b_reg, imm_reg, alu_out, mdr;
  logic [DATA_W-1:0]     rf [RF_DEPTH];
  logic [DATA_W-1:0]     imm_value, alu_b, alu_value;
  logic [RF_ADDRESS-1:0] rs1_addr, rs2_addr, rd_addr;
  logic                  wb_en;

  assign rs1_addr = ir[15 +: RF_ADDRESS];
  assign rs2_addr = ir[20 +: RF_ADDRESS];
  assign rd_addr  = ir[7 +: RF_ADDRESS];

  assign imem_addr   = pc;
  assign dmem_addr   = alu_out[DM_ADDRESS-1:0];
  assign dmem_wdata  = b_reg;
  assign opcode      = ir[6:0];
  assign funct7      = ir[31:25];
  assign funct3      = ir[14:12];
  assign alu_result  = alu_out;
  assign dbg_rf_data = (dbg_rf_addr == '0) ? '0 : rf[dbg_rf_addr];

  always_comb begin
    imm_value = '0;
    case (ir[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        imm_value = {{(DATA_W-12){ir[31]}}, ir[31:20]};
      7'b0100011:
        imm_value = {{(DATA_W-12){ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011:
        imm_value = {{(DATA_W-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:
        imm_value = '0;
    endcase
  end

  always_comb begin
    alu_b     = alu_src ? imm_reg : b_reg;
    alu_value = '0;
    case (alu_cc)
      4'b0000: alu_value = a_reg & alu_b;
      4'b0001: alu_value = a_reg | alu_b;
      4'b0010: alu_value = a_reg + alu_b;
      4'b0110: alu_value = a_reg - alu_b;
      4'b0111: alu_value = {{(DATA_W-1){1'b0}}, ($signed(a_reg) < $signed(alu_b))};
      4'b1100: alu_value = ~(a_reg | alu_b);
      4'b1000: alu_value = a_reg ^ alu_b;
      default: alu_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      instr_done <= 1'b0;
    end else begin
      state      <= state_next;
      instr_done <= done_next;
    end
  end

  // Every path back to FETCH retires an instruction; done_next is registered
  // so the pulse lands in the first FETCH cycle of the next instruction.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (imem_ready) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (branch) begin
          state_next = S_FETCH;
          done_next  = 1'b1;
        end else if (mem_read || mem_write) begin
          state_next = S_MEM;
        end else if (reg_write) begin
          state_next = S_WB;
        end else begin
          state_next = S_FETCH;
          done_next  = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (!mem_write && reg_write) begin
            state_next = S_WB;
          end else begin
            state_next = S_FETCH;
            done_next  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        done_next  = 1'b1;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == S_FETCH);
    dmem_req = (state == S_MEM);
    dmem_we  = (state == S_MEM) && mem_write;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      old_pc  <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_reg <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir     <= imem_rdata;
            old_pc <= pc;
            pc     <= pc + PC_W'(4);
          end
        end
        S_DECODE: begin
          a_reg   <= rf[rs1_addr];
          b_reg   <= rf[rs2_addr];
          imm_reg <= imm_value;
        end
        S_EXEC: begin
          alu_out <= alu_value;
          // Branch target is relative to the fetch address, not the incremented PC.
          if (branch && (alu_value == '0)) pc <= old_pc + imm_reg[PC_W-1:0];
        end
        S_MEM: begin
          if (dmem_ready && !mem_write) mdr <= dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign wb_en = (state == S_WB) && reg_write && (rd_addr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[rd_addr] <= mem2reg ? mdr : alu_out;
    end
  end

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench for multicycle_data_path: runs a short RV32 program with
// hand-computed results, memory wait states, branches, PC wrap and reset.
module tb_multicycle_data_path;

  localparam logic [5:0] C_ALU_R = 6'b100000;
  localparam logic [5:0] C_ALU_I = 6'b101000;
  localparam logic [5:0] C_STORE = 6'b001100;
  localparam logic [5:0] C_LOAD  = 6'b111010;
  localparam logic [5:0] C_BR    = 6'b000001;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write, mem2reg, alu_src, mem_write, mem_read, branch;
  logic [3:0]  alu_cc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_req, dmem_we;
  logic [8:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic        instr_done;
  logic [4:0]  dbg_rf_addr;
  logic [31:0] dbg_rf_data;

  int tests_run = 0;
  int fails = 0;

  logic [7:0]  fetch_addr0;
  logic [6:0]  opcode0;
  logic        fetch_unstable, mem_seen, mem_unstable;
  logic [8:0]  mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic        mem_we_s;
  int          mem_cycles;

  multicycle_data_path dut (
    .clk(clk), .reset(reset),
    .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src),
    .mem_write(mem_write), .mem_read(mem_read), .branch(branch), .alu_cc(alu_cc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .alu_result(alu_result), .instr_done(instr_done),
    .dbg_rf_addr(dbg_rf_addr), .dbg_rf_data(dbg_rf_data)
  );

  always #5 clk = ~clk;

  // Starts at a negedge in FETCH; returns cycles from FETCH entry to the
  // instr_done pulse (-1 on timeout) and records handshake stability.
  task automatic run_instr(input logic [31:0] instr, input logic [5:0] ctl, input logic [3:0] cc,
                           input int iwait, input int dwait, input logic [31:0] rdata,
                           output int cycles);
    int iw, dw;
    {reg_write, mem2reg, alu_src, mem_write, mem_read, branch} = ctl;
    alu_cc = cc;
    imem_rdata = instr;
    dmem_rdata = rdata;
    iw = 0;
    dw = 0;
    cycles = -1;
    fetch_addr0 = imem_addr;
    opcode0 = opcode;
    fetch_unstable = 1'b0;
    mem_seen = 1'b0;
    mem_unstable = 1'b0;
    mem_cycles = 0;
    for (int n = 1; n <= 60; n++) begin
      if (imem_req && (imem_addr !== fetch_addr0 || opcode !== opcode0)) fetch_unstable = 1'b1;
      if (dmem_req) begin
        mem_cycles++;
        if (!mem_seen) begin
          mem_seen = 1'b1;
          mem_addr_s = dmem_addr;
          mem_wdata_s = dmem_wdata;
          mem_we_s = dmem_we;
        end else if (dmem_addr !== mem_addr_s || dmem_wdata !== mem_wdata_s || dmem_we !== mem_we_s) begin
          mem_unstable = 1'b1;
        end
      end
      imem_ready = imem_req && (iw >= iwait);
      if (imem_req) iw++;
      dmem_ready = dmem_req && (dw >= dwait);
      if (dmem_req) dw++;
      @(posedge clk);
      @(negedge clk);
      if (instr_done) begin
        cycles = n;
        break;
      end
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic read_rf(input logic [4:0] addr, output logic [31:0] data);
    dbg_rf_addr = addr;
    #1;
    data = dbg_rf_data;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    {reg_write, mem2reg, alu_src, mem_write, mem_read, branch} = '0;
    alu_cc = '0; imem_rdata = '0; imem_ready = 1'b0;
    dmem_rdata = '0; dmem_ready = 1'b0; dbg_rf_addr = '0;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || instr_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got req/dreq/we/done=%b%b%b%b expected 0000", imem_req, dmem_req, dmem_we, instr_done);
    end
    tests_run++;
    if (imem_addr !== 8'h00 || alu_result !== 32'h0 || opcode !== 7'h0) begin
      fails++;
      $display("[TB] FAIL reset_regs: got pc=%h alu=%h op=%h expected 0", imem_addr, alu_result, opcode);
    end
    for (int i = 0; i < 32; i++) begin
      read_rf(5'(i), d);
      tests_run++;
      if (d !== 32'h0) begin
        fails++;
        $display("[TB] FAIL reset_rf[%0d]: got %h expected 0", i, d);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_release: got imem_req=%b expected 0", imem_req);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      fails++;
      $display("[TB] FAIL fetch_after_release: got req=%b addr=%h expected 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_addi;
    int cyc;
    logic [31:0] d;
    run_instr(32'h00500093, C_ALU_I, 4'b0010, 0, 0, 32'h0, cyc);
    read_rf(5'd1, d);
    tests_run++;
    if (cyc !== 4) begin fails++; $display("[TB] FAIL addi_latency: got %0d expected 4", cyc); end
    tests_run++;
    if (d !== 32'd5 || alu_result !== 32'd5) begin
      fails++; $display("[TB] FAIL addi_result: got x1=%h alu=%h expected 5/5", d, alu_result);
    end
    tests_run++;
    if (imem_addr !== 8'h04) begin fails++; $display("[TB] FAIL addi_pc: got %h expected 04", imem_addr); end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (instr_done !== 1'b0) begin fails++; $display("[TB] FAIL done_pulse_width: got %b expected 0", instr_done); end
  endtask

  task automatic test_store;
    int cyc;
    run_instr(32'h00102423, C_STORE, 4'b0010, 0, 2, 32'h0, cyc);
    tests_run++;
    if (cyc !== 6) begin fails++; $display("[TB] FAIL store_latency: got %0d expected 6", cyc); end
    tests_run++;
    if (!mem_seen || mem_addr_s !== 9'd8 || mem_wdata_s !== 32'd5 || mem_we_s !== 1'b1) begin
      fails++;
      $display("[TB] FAIL store_bus: got seen=%b addr=%h data=%h we=%b expected 1/008/5/1", mem_seen, mem_addr_s, mem_wdata_s, mem_we_s);
    end
    tests_run++;
    if (mem_unstable !== 1'b0 || mem_cycles !== 3) begin
      fails++; $display("[TB] FAIL store_hold: got unstable=%b cycles=%0d expected 0/3", mem_unstable, mem_cycles);
    end
  endtask

  task automatic test_branch_taken;
    int cyc;
    run_instr(32'hFE000EE3, C_BR, 4'b0110, 0, 0, 32'h0, cyc);
    tests_run++;
    if (cyc !== 3) begin fails++; $display("[TB] FAIL beq_taken_latency: got %0d expected 3", cyc); end
    tests_run++;
    if (imem_addr !== 8'h04) begin fails++; $display("[TB] FAIL beq_taken_target: got %h expected 04", imem_addr); end
  endtask

  task automatic test_load;
    int cyc;
    logic [31:0] d;
    run_instr(32'h00802103, C_LOAD, 4'b0010, 0, 2, 32'd5, cyc);
    read_rf(5'd2, d);
    tests_run++;
    if (cyc !== 7) begin fails++; $display("[TB] FAIL load_latency: got %0d expected 7", cyc); end
    tests_run++;
    if (d !== 32'd5 || mem_we_s !== 1'b0 || mem_addr_s !== 9'd8) begin
      fails++; $display("[TB] FAIL load_result: got x2=%h we=%b addr=%h expected 5/0/008", d, mem_we_s, mem_addr_s);
    end
    tests_run++;
    if (imem_addr !== 8'h08) begin fails++; $display("[TB] FAIL load_pc: got %h expected 08", imem_addr); end
  endtask

  task automatic test_branch_not_taken;
    int cyc;
    run_instr(32'hFE008EE3, C_BR, 4'b0110, 0, 0, 32'h0, cyc);
    tests_run++;
    if (cyc !== 3 || imem_addr !== 8'h0C) begin
      fails++; $display("[TB] FAIL beq_not_taken: got cyc=%0d pc=%h expected 3/0c", cyc, imem_addr);
    end
    tests_run++;
    if (alu_result !== 32'd5) begin fails++; $display("[TB] FAIL beq_alu: got %h expected 5", alu_result); end
  endtask

  task automatic test_fetch_wait;
    int cyc;
    logic [31:0] d;
    run_instr(32'h00208193, C_ALU_I, 4'b0010, 3, 0, 32'h0, cyc);
    read_rf(5'd3, d);
    tests_run++;
    if (cyc !== 7) begin fails++; $display("[TB] FAIL fetch_wait_latency: got %0d expected 7", cyc); end
    tests_run++;
    if (fetch_unstable !== 1'b0 || opcode0 !== 7'b1100011) begin
      fails++; $display("[TB] FAIL fetch_wait_hold: got unstable=%b op=%b expected 0/1100011", fetch_unstable, opcode0);
    end
    tests_run++;
    if (d !== 32'd7 || imem_addr !== 8'h10) begin
      fails++; $display("[TB] FAIL fetch_wait_result: got x3=%h pc=%h expected 7/10", d, imem_addr);
    end
  endtask

  task automatic test_x0_and_wrap;
    int cyc;
    logic [31:0] d;
    run_instr(32'h00700013, C_ALU_I, 4'b0010, 0, 0, 32'h0, cyc);
    read_rf(5'd0, d);
    tests_run++;
    if (d !== 32'h0 || alu_result !== 32'd7) begin
      fails++; $display("[TB] FAIL x0_write: got x0=%h alu=%h expected 0/7", d, alu_result);
    end
    run_instr(32'h0E000463, C_BR, 4'b0110, 0, 0, 32'h0, cyc);
    tests_run++;
    if (imem_addr !== 8'hFC) begin fails++; $display("[TB] FAIL jump_to_fc: got %h expected fc", imem_addr); end
    run_instr(32'h00100213, C_ALU_I, 4'b0010, 0, 0, 32'h0, cyc);
    read_rf(5'd4, d);
    tests_run++;
    if (imem_addr !== 8'h00 || d !== 32'd1) begin
      fails++; $display("[TB] FAIL pc_wrap: got pc=%h x4=%h expected 00/1", imem_addr, d);
    end
  endtask

  task automatic test_alu_ops;
    logic [31:0] instrs [10] = '{32'h001182B3, 32'h001182B3, 32'h001182B3, 32'h001182B3, 32'h001182B3,
                                 32'h001182B3, 32'h003082B3, 32'h001182B3, 32'h00128333, 32'h001182B3};
    logic [3:0]  ccs    [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000,
                                 4'b0111, 4'b0111, 4'b1100, 4'b0111, 4'b1111};
    logic [4:0]  rds    [10] = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd6, 5'd5};
    logic [31:0] exps   [10] = '{32'd5, 32'd7, 32'd12, 32'd2, 32'd2,
                                 32'd0, 32'd1, 32'hFFFFFFF8, 32'd1, 32'd0};
    int cyc;
    logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      run_instr(instrs[i], C_ALU_R, ccs[i], 0, 0, 32'h0, cyc);
      read_rf(rds[i], d);
      tests_run++;
      if (d !== exps[i] || alu_result !== exps[i]) begin
        fails++;
        $display("[TB] FAIL alu_op[%0d] cc=%b: got rf=%h alu=%h expected %h", i, ccs[i], d, alu_result, exps[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mem;
    logic [31:0] d;
    int bad_rf;
    {reg_write, mem2reg, alu_src, mem_write, mem_read, branch} = C_STORE;
    alu_cc = 4'b0010;
    imem_rdata = 32'h00102423;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    for (int n = 0; n < 10 && !dmem_req; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    tests_run++;
    if (dmem_req !== 1'b1) begin fails++; $display("[TB] FAIL reach_mem: got dmem_req=%b expected 1", dmem_req); end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0) begin
      fails++; $display("[TB] FAIL async_reset_req: got dreq=%b we=%b ireq=%b expected 000", dmem_req, dmem_we, imem_req);
    end
    tests_run++;
    if (imem_addr !== 8'h00 || alu_result !== 32'h0) begin
      fails++; $display("[TB] FAIL async_reset_regs: got pc=%h alu=%h expected 0", imem_addr, alu_result);
    end
    bad_rf = 0;
    for (int i = 0; i < 32; i++) begin
      read_rf(5'(i), d);
      if (d !== 32'h0) bad_rf++;
    end
    tests_run++;
    if (bad_rf !== 0) begin fails++; $display("[TB] FAIL async_reset_rf: got %0d nonzero entries expected 0", bad_rf); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL rerelease_idle: got %b expected 0", imem_req); end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      fails++; $display("[TB] FAIL rerelease_fetch: got req=%b addr=%h expected 1/00", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store();
    test_branch_taken();
    test_load();
    test_branch_not_taken();
    test_fetch_wait();
    test_x0_and_wrap();
    test_alu_ops();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
